// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and width helpers for the synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Read-port behaviour selectors for the FWFT parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address width for a storage array of 'depth' entries (never below 1 bit)
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : WIDTH x DEPTH storage array, synchronous write port and
//                asynchronous read port. Contents are intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store write data on accepted writes only; no reset on the array
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync_param
//  Description : Parameterised single-clock FIFO with occupancy count,
//                almost-full/almost-empty flags, overflow/underflow pulses and
//                selectable registered-read or first-word-fall-through output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              d_in,
    input  logic                          write,
    input  logic                          read,
    output logic [WIDTH-1:0]              d_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [fifo_cnt_w(DEPTH)-1:0]  count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int c_pw = fifo_ptr_w(DEPTH);
    localparam int c_cw = fifo_cnt_w(DEPTH);

    localparam logic [c_pw-1:0] c_ptr_last = c_pw'(DEPTH - 1);
    localparam logic [c_pw-1:0] c_ptr_one  = c_pw'(1);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_full = c_cw'(DEPTH);

    // ------------------------------------------------------------------
    // Parameter legality, checked at elaboration
    // ------------------------------------------------------------------
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_err_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (AE_THRESH >= AF_THRESH) begin : g_err_thresh
        $error("fifo_sync_param: AE_THRESH must be below AF_THRESH");
    end
    if (WIDTH < 1) begin : g_err_width
        $error("fifo_sync_param: WIDTH must be >= 1");
    end

    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [WIDTH-1:0] w_rd_data;

    // Status flags decode the registered count only
    assign w_full       = (r_count == c_cnt_full);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (int'(r_count) >= AF_THRESH);
    assign almost_empty = (int'(r_count) <= AE_THRESH);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A read while full frees a slot in the same cycle, so the write may proceed
    assign w_rd_acc = read && !w_empty;
    assign w_wr_acc = write && (!w_full || read);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (c_pw)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (d_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Pointer advance with explicit wrap at the last entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_one;
            end
        end
    end

    // Occupancy tracks accepted writes minus accepted reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Rejected requests produce a single-cycle pulse on the following cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= write && !w_wr_acc;
            r_underflow <= read && !w_rd_acc;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head entry is visible whenever data is present; zero when empty
        assign d_out = w_empty ? '0 : w_rd_data;
    end else begin : g_std
        logic [WIDTH-1:0] r_d_out;

        // Capture the head entry on an accepted read, otherwise hold
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_d_out <= '0;
            end else if (w_rd_acc) begin
                r_d_out <= w_rd_data;
            end
        end

        assign d_out = r_d_out;
    end

endmodule : fifo_sync_param
`default_nettype wire

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  WIDTH      8   data width in bits, >=1
  DEPTH      8   entries, power of two, >=2
  AF_THRESH  6   almost_full asserts at count >= AF_THRESH
  AE_THRESH  1   almost_empty asserts at count <= AE_THRESH
  FWFT       0   0 = registered-read mode, 1 = first-word-fall-through mode
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk           in   1                     single clock; all state updates on rising edge
  rst           in   1                     asynchronous, active-low reset
  d_in          in   WIDTH                 write data
  write         in   1                     write request
  read          in   1                     read request
  d_out         out  WIDTH                 read data
  full          out  1                     count == DEPTH
  empty         out  1                     count == 0
  almost_full   out  1                     count >= AF_THRESH
  almost_empty  out  1                     count <= AE_THRESH
  count         out  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
  overflow      out  1                     one-cycle pulse: write rejected
  underflow     out  1                     one-cycle pulse: read rejected
REQ-003 Design SHALL use one clock, clk; reset rst SHALL be asynchronous and active-low.

Function
REQ-004 rd_acc SHALL = read && !empty; wr_acc SHALL = write && (!full || read).
REQ-005 Accepted write SHALL store d_in at wr_ptr; wr_ptr SHALL advance by 1, wrapping DEPTH-1 -> 0.
REQ-006 Accepted read SHALL advance rd_ptr by 1, wrapping DEPTH-1 -> 0.
REQ-007 count SHALL update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-008 Full with read && write: both accepted, count stays DEPTH, full stays 1.
REQ-009 Empty with read && write: write accepted, read rejected, count -> 1, underflow pulses.
REQ-010 full, empty, almost_full, almost_empty SHALL be combinational decodes of registered count.
REQ-011 overflow SHALL be registered, high exactly one cycle after a cycle with write && !wr_acc.
REQ-012 underflow SHALL be registered, high exactly one cycle after a cycle with read && !rd_acc.
REQ-013 FWFT=0: d_out SHALL register mem[rd_ptr] on rd_acc (1-cycle latency), else hold.
REQ-014 FWFT=1: d_out SHALL show mem[rd_ptr] combinationally while !empty, 0 while empty; rd_acc pops.
REQ-015 FWFT=1: first write into empty FIFO SHALL appear on d_out the cycle after that edge.
REQ-016 Storage contents SHALL be unaffected by rejected writes and SHALL not be reset.

Reset
REQ-017 rst low SHALL immediately force wr_ptr, rd_ptr, count, overflow, underflow and registered d_out to 0.
REQ-018 Reset mid-operation SHALL discard all entries: empty=1, almost_empty=1, full=0 while rst low.
REQ-019 First accepted write after rst deasserts SHALL go to entry 0.

Structure
REQ-020 Package fifo_pkg SHALL hold constants FIFO_MODE_STD=0, FIFO_MODE_FWFT=1 and the pointer/count width helper.
REQ-021 Storage SHALL be sub-module fifo_ram (WIDTH x DEPTH, synchronous write, asynchronous read).
REQ-022 Elaboration SHALL reject non-power-of-two DEPTH and AE_THRESH >= AF_THRESH.

Verification (WIDTH=8, DEPTH=8, AF=6, AE=1)
REQ-023 Fill: write 0x01..0x08 -> count 8, full=1, almost_full from 6th write; 9th write -> overflow pulse, count 8.
REQ-024 Drain FWFT=0: 8 reads -> d_out 0x01..0x08, each 1 cycle after read; 9th read -> underflow, d_out holds 0x08.
REQ-025 Wrap: write 5, read 5, write 8 (0xA0..0xA7), read 8 -> data in order, pointers wrapped, empty=1.
REQ-026 Simultaneous: full + read&write 0x55 -> count 8, no overflow; empty + read&write 0x33 -> count 1, underflow.
REQ-027 FWFT=1: write 0x9C into empty -> d_out 0x9C next cycle with no read; read -> empty=1, d_out 0.
REQ-028 Reset: rst low with count 4 -> count 0, empty=1, d_out 0 before next clk edge.
